dm_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer in front of the word-addressed data memory. Port A is the CPU MEM-stage load/store path. Port B is an external bridge/debug master. The block grants the single DM port each cycle by round-robin on conflict, generates DM byte enables from CPU access size, stalls the CPU when it loses, and returns a registered read response to port B.

---
 rtl/dm_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU MEM-stage port vs. external bridge/debug master.
// Round-robin on conflict, CPU byte-enable generation, registered port-B read return.
module dm_port_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [1:0]       cpu_size,
  input  logic [31:0]      cpu_wdata,
  input  logic [31:0]      cpu_pc,
  output logic             cpu_stall,
  output logic             cpu_fault,
  output logic [31:0]      cpu_rdata,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  input  logic [3:0]       ext_byteen,
  output logic             ext_gnt,
  output logic             ext_rvalid,
  output logic [31:0]      ext_rdata,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_we,
  output logic [3:0]       dm_byteen,
  output logic [31:0]      dm_pc,
  input  logic [31:0]      dm_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    WIN_CPU = 1'b0,
    WIN_EXT = 1'b1
  } winner_e;

  winner_e          last_winner_q, last_winner_d;
  logic             ext_rvalid_q, ext_rvalid_d;
  logic [31:0]      ext_rdata_q, ext_rdata_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic       cpu_valid;
  logic       conflict;
  logic       cpu_win;
  logic       ext_win;
  logic       ext_oor;
  logic [3:0] cpu_byteen;

  // CPU access legality; a faulted access never competes for the port
  always_comb begin
    cpu_fault = 1'b0;
    if (cpu_req) begin
      case (cpu_size)
        2'd0:    cpu_fault = 1'b0;
        2'd1:    cpu_fault = cpu_addr[0];
        2'd2:    cpu_fault = |cpu_addr[1:0];
        default: cpu_fault = 1'b1;
      endcase
      if (cpu_addr >= ADDR_LIMIT) cpu_fault = 1'b1;
    end
  end

  // Grant: on conflict the port opposite the last winner takes the cycle
  always_comb begin
    cpu_valid = cpu_req & ~cpu_fault;
    conflict  = cpu_valid & ext_req;
    cpu_win   = cpu_valid & (~ext_req | (last_winner_q == WIN_EXT));
    ext_win   = ext_req & ~cpu_win;
    ext_oor   = ext_addr >= ADDR_LIMIT;
    cpu_stall = cpu_valid & ext_win;
    ext_gnt   = ext_win;
  end

  always_comb begin
    case (cpu_size)
      2'd0:    cpu_byteen = 4'b0001 << cpu_addr[1:0];
      2'd1:    cpu_byteen = cpu_addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    cpu_byteen = 4'b1111;
      default: cpu_byteen = 4'b0000;
    endcase
  end

  // DM request mux; out-of-range port-B accesses are granted but not forwarded
  always_comb begin
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_we     = 1'b0;
    dm_byteen = 4'h0;
    dm_pc     = 32'h0;
    if (!reset) begin
      if (cpu_win) begin
        dm_addr   = cpu_addr;
        dm_wdata  = cpu_wdata;
        dm_we     = cpu_we;
        dm_byteen = cpu_byteen;
        dm_pc     = cpu_pc;
      end else if (ext_win && !ext_oor) begin
        dm_addr   = {ext_addr[31:2], 2'b00};
        dm_wdata  = ext_wdata;
        dm_we     = ext_we;
        dm_byteen = ext_byteen;
      end
    end
  end

  assign cpu_rdata = dm_rdata;

  always_comb begin
    last_winner_d  = last_winner_q;
    conflict_cnt_d = conflict_cnt_q;
    ext_rvalid_d   = ext_win & ~ext_we;
    ext_rdata_d    = ext_rdata_q;
    if (conflict) begin
      last_winner_d = ext_win ? WIN_EXT : WIN_CPU;
      if (!(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
    if (ext_rvalid_d) ext_rdata_d = ext_oor ? OOR_RDATA : dm_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q  <= WIN_EXT;
      conflict_cnt_q <= '0;
      ext_rvalid_q   <= 1'b0;
      ext_rdata_q    <= 32'h0;
    end else begin
      last_winner_q  <= last_winner_d;
      conflict_cnt_q <= conflict_cnt_d;
      ext_rvalid_q   <= ext_rvalid_d;
      ext_rdata_q    <= ext_rdata_d;
    end
  end

  assign ext_rvalid   = ext_rvalid_q;
  assign ext_rdata    = ext_rdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a request-level reference model queues the
// expected per-cycle response; a negedge monitor pops and compares.
module tb_dm_port_arbiter;

  localparam logic [31:0] LIMIT     = 32'h0000_3000;
  localparam int          CNT_W     = 5;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;
  localparam int          MEM_WORDS = 32'h3000 / 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]      cpu_addr = '0, cpu_wdata = '0, cpu_pc = '0;
  logic [1:0]       cpu_size = '0;
  logic             cpu_stall, cpu_fault;
  logic [31:0]      cpu_rdata;
  logic             ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0]      ext_addr = '0, ext_wdata = '0;
  logic [3:0]       ext_byteen = '0;
  logic             ext_gnt, ext_rvalid;
  logic [31:0]      ext_rdata;
  logic [31:0]      dm_addr, dm_wdata, dm_pc;
  logic             dm_we;
  logic [3:0]       dm_byteen;
  logic [31:0]      dm_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  dm_port_arbiter #(.ADDR_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
    .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_byteen(ext_byteen), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_byteen(dm_byteen),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT
  logic [31:0] dm_mem [0:MEM_WORDS-1];
  always_comb dm_rdata = (dm_addr < LIMIT) ? dm_mem[dm_addr[13:2]] : 32'h0;
  always @(posedge clk)
    if (dm_we && dm_addr < LIMIT)
      for (int i = 0; i < 4; i++)
        if (dm_byteen[i]) dm_mem[dm_addr[13:2]][8*i +: 8] <= dm_wdata[8*i +: 8];

  typedef struct {
    logic        gnt, stall, fault, we, rvalid;
    logic [31:0] cpu_rdata, addr, wdata, pc, rdata;
    logic [3:0]  be;
    int          cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  bit          m_last_ext = 1'b1;
  int          m_cnt = 0;
  bit          m_rv = 1'b0;
  logic [31:0] m_rd = 32'h0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return (a < LIMIT) ? ref_mem[a / 4] : 32'h0;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %h want %h (t=%0t)", tag, name, act, want, $time);
    end
  endtask

  // One bus cycle: drive inputs, queue the expected response, advance the model
  task automatic cyc(input bit rst,
                     input bit creq, input bit cwe, input logic [31:0] caddr, input logic [1:0] csz,
                     input logic [31:0] cwd, input logic [31:0] cpc,
                     input bit ereq, input bit ewe, input logic [31:0] eaddr,
                     input logic [31:0] ewd, input logic [3:0] ebe,
                     input string tag, output bit stalled, output bit granted);
    exp_t e;
    bit   flt, cv, cw, ew;
    int   nbytes;
    @(posedge clk);
    #1;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_size = csz;
    cpu_wdata = cwd; cpu_pc = cpc; ext_req = ereq; ext_we = ewe; ext_addr = eaddr;
    ext_wdata = ewd; ext_byteen = ebe;

    nbytes = 1 << csz;
    flt = creq && (csz == 2'd3 || (caddr % nbytes) != 0 || caddr >= LIMIT);
    cv  = creq && !flt;
    cw  = cv && (!ereq || m_last_ext);
    ew  = ereq && !cw;

    e = '{gnt: ew, stall: cv && ew, fault: flt, we: 1'b0, rvalid: m_rv,
          cpu_rdata: 32'h0, addr: 32'h0, wdata: 32'h0, pc: 32'h0, rdata: m_rd,
          be: 4'h0, cnt: m_cnt, tag: tag};
    if (!rst && cw) begin
      e.addr = caddr; e.we = cwe; e.wdata = cwd; e.pc = cpc;
      e.be = 4'(((1 << nbytes) - 1) << (caddr % 4));
    end else if (!rst && ew && eaddr < LIMIT) begin
      e.addr = eaddr & ~32'h3; e.we = ewe; e.wdata = ewd; e.be = ebe;
    end
    e.cpu_rdata = ref_rd(e.addr);
    exp_q.push_back(e);

    if (rst) begin
      m_last_ext = 1'b1; m_cnt = 0; m_rv = 1'b0; m_rd = 32'h0;
    end else begin
      if (cv && ereq) begin
        m_last_ext = ew;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_rv = ew && !ewe;
      if (m_rv) m_rd = (eaddr >= LIMIT) ? 32'hDEAD_BEEF : ref_rd(eaddr & ~32'h3);
      if (e.we)
        for (int i = 0; i < 4; i++)
          if (e.be[i]) ref_mem[e.addr / 4][8*i +: 8] = e.wdata[8*i +: 8];
    end
    stalled = e.stall;
    granted = ew;
  endtask

  // Monitor: every cycle the DUT presents a full response set
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk(me.tag, "ext_gnt",      32'(ext_gnt),      32'(me.gnt));
      chk(me.tag, "cpu_stall",    32'(cpu_stall),    32'(me.stall));
      chk(me.tag, "cpu_fault",    32'(cpu_fault),    32'(me.fault));
      chk(me.tag, "cpu_rdata",    cpu_rdata,         me.cpu_rdata);
      chk(me.tag, "dm_addr",      dm_addr,           me.addr);
      chk(me.tag, "dm_we",        32'(dm_we),        32'(me.we));
      chk(me.tag, "dm_byteen",    32'(dm_byteen),    32'(me.be));
      chk(me.tag, "dm_wdata",     dm_wdata,          me.wdata);
      chk(me.tag, "dm_pc",        dm_pc,             me.pc);
      chk(me.tag, "ext_rvalid",   32'(ext_rvalid),   32'(me.rvalid));
      chk(me.tag, "ext_rdata",    ext_rdata,         me.rdata);
      chk(me.tag, "conflict_cnt", 32'(conflict_cnt), 32'(me.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit s, g;
    bit c_hold, e_hold, rst;
    logic        creq, cwe, ereq, ewe;
    logic [31:0] caddr, cwd, cpc, eaddr, ewd;
    logic [1:0]  csz;
    logic [3:0]  ebe;

    for (int i = 0; i < MEM_WORDS; i++) begin
      dm_mem[i]  = 32'(i) * 32'h9E37_79B9;
      ref_mem[i] = 32'(i) * 32'h9E37_79B9;
    end
    dm_mem[32'h40 / 4]  = 32'h1234_5678;
    ref_mem[32'h40 / 4] = 32'h1234_5678;

    cyc(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "rst0", s, g);
    cyc(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "rst1", s, g);
    cyc(0, 1, 1, 32'h106, 2'd0, 32'hAB, 32'h400,  0, 0, 0, 0, 0, "cpu_sb", s, g);
    cyc(0, 1, 1, 32'h101, 2'd1, 32'h55, 32'h404,  1, 0, 32'h200, 0, 0, "cpu_sh_fault", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "fault_rsp", s, g);
    cyc(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "rst2", s, g);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 32'h10, 2'd2, 0, 32'h408,  1, 0, 32'h20, 0, 4'hF, "rr", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "rr_cnt", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h40, 0, 0, "b_rd40", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "b_rd40_rsp", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "b_rd40_after", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h3004, 32'hCAFE_F00D, 4'hF, "b_wr_oor", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h3004, 0, 0, "b_rd_oor", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h80, 32'h1111_2222, 4'h0, "b_wr_be0", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h82, 0, 0, "b_rd80", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "b_rd80_rsp", s, g);
    cyc(0, 1, 0, 32'h14, 2'd2, 0, 32'h40C,  1, 0, 32'h24, 0, 0, "mid_conflict", s, g);
    cyc(1, 1, 0, 32'h14, 2'd2, 0, 32'h40C,  1, 0, 32'h24, 0, 0, "mid_reset", s, g);
    cyc(0, 1, 0, 32'h14, 2'd2, 0, 32'h40C,  1, 0, 32'h24, 0, 0, "post_reset", s, g);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "post_reset_idle", s, g);

    // Randomised traffic honouring the hold rules of both requesters
    c_hold = 1'b0; e_hold = 1'b0;
    creq = 0; cwe = 0; caddr = 0; csz = 0; cwd = 0; cpc = 0;
    ereq = 0; ewe = 0; eaddr = 0; ewd = 0; ebe = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!c_hold) begin
        creq  = ($urandom % 4) != 0;
        cwe   = $urandom % 2;
        caddr = (($urandom % 10) == 0) ? LIMIT + 32'($urandom % 64) : 32'($urandom % 32'h3000);
        csz   = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
        cwd   = $urandom;
        cpc   = $urandom & ~32'h3;
      end
      if (!e_hold) begin
        ereq  = ($urandom % 3) != 0;
        ewe   = $urandom % 2;
        eaddr = (($urandom % 10) == 0) ? LIMIT + 32'($urandom % 64) : 32'($urandom % 32'h3000);
        ewd   = $urandom;
        ebe   = 4'($urandom);
      end
      rst = ($urandom % 97) == 0;
      cyc(rst, creq, cwe, caddr, csz, cwd, cpc, ereq, ewe, eaddr, ewd, ebe, "rand", s, g);
      c_hold = s;
      e_hold = ereq && !g;
    end
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "drain", s, g);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
